// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: walks the shared BCD decoder across the digit
// positions with a dark guard band per slot, optional leading-zero blanking and frame-aligned loads.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    lz_en,
  output logic                    load_ack,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [3:0]              bcd
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]                cnt;
  logic [IW-1:0]                idx;
  logic [NUM_DIGITS-1:0][3:0]   stg;
  logic [NUM_DIGITS-1:0][3:0]   frm;
  logic                         pending;
  logic                         committed;
  logic                         slot_end;
  logic                         frame_end;
  logic [NUM_DIGITS-1:0]        blank;
  logic [NUM_DIGITS-1:0]        an_n;
  logic [3:0]                   digit_n;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // A load landing on the frame-end edge stays pending: the commit takes the older stg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg       <= '1;
      frm       <= '1;
      pending   <= 1'b0;
      committed <= 1'b0;
    end else begin
      committed <= frame_end && pending;
      if (frame_end && pending) begin
        frm     <= stg;
        pending <= 1'b0;
      end
      if (load) begin
        stg     <= digits_in;
        pending <= 1'b1;
      end
    end
  end

  // A digit is blank when it and every more significant digit are zero.
  always_comb begin : blank_calc
    logic zero_run;
    blank    = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (frm[i] == 4'd0);
      blank[i] = lz_en && zero_run;
    end
  end

  always_comb begin
    digit_n = blank[idx] ? 4'hF : frm[idx];
    an_n    = '1;
    if (cnt >= CNT_GUARD) an_n[idx] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an       <= '1;
      bcd      <= 4'hF;
      load_ack <= 1'b0;
    end else begin
      an       <= an_n;
      bcd      <= digit_n;
      load_ack <= committed;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: a frame-level behavioural model checked every cycle,
// plus hand-computed expectations at chosen cycles.
module tb_seg_scan_ctrl;

  localparam int N = 4;
  localparam int R = 8;
  localparam int G = 2;
  localparam int F = N * R;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   digits_in = '0;
  logic          lz_en = 1'b0;
  logic          load_ack;
  logic [N-1:0]  an;
  logic [3:0]    bcd;

  int vectors = 0;
  int errors  = 0;
  int edges   = 0;

  seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .GUARD(G)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .digits_in (digits_in),
    .lz_en     (lz_en),
    .load_ack  (load_ack),
    .an        (an),
    .bcd       (bcd)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; edge n produces the outputs of "cycle n".
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic compare(input string name, input int cyc, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Frame-level model: loads queue up, each frame boundary shows the newest one.
  logic [3:0]  mframe [N];
  logic [15:0] loads [$];
  int          last_commit;
  logic        load_prev, lz_prev;
  logic [15:0] din_prev;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n || edges == 0) begin
        compare("reset_an", edges, {{(4-N){1'b0}}, an}, 4'hF);
        compare("reset_bcd", edges, bcd, 4'hF);
        compare("reset_ack", edges, {3'b0, load_ack}, 4'h0);
        if (!rst_n) begin
          for (int i = 0; i < N; i++) mframe[i] = 4'hF;
          loads.delete();
          last_commit = -10;
        end
      end else begin
        int n, p, slot, pos, ms;
        logic [3:0] e_an, e_bcd;
        n    = edges;
        p    = n - 1;
        slot = p % R;
        pos  = (p / R) % N;
        e_an = (slot >= G) ? ~(4'b0001 << pos) : 4'hF;
        ms = 0;
        for (int i = 0; i < N; i++) if (mframe[i] != 4'd0) ms = i;
        e_bcd = (lz_prev && pos > ms) ? 4'hF : mframe[pos];
        compare("model_an", n, an, e_an);
        compare("model_bcd", n, bcd, e_bcd);
        compare("model_ack", n, {3'b0, load_ack}, {3'b0, (last_commit == n - 1)});
        if (n % F == 0 && loads.size() > 0) begin
          logic [15:0] v;
          v = loads[$];
          for (int i = 0; i < N; i++) mframe[i] = v[4*i +: 4];
          loads.delete();
          last_commit = n;
        end
        if (load_prev) loads.push_back(din_prev);
      end
      load_prev = load;
      din_prev  = digits_in;
      lz_prev   = lz_en;
    end
  end

  task automatic toCycle(input int k);
    while (edges < k) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Drives load so that it is sampled by rising edge k.
  task automatic applyStimulus(input int k, input logic [15:0] din);
    toCycle(k - 1);
    load      = 1'b1;
    digits_in = din;
    toCycle(k);
    load = 1'b0;
  endtask

  // sel: 0 = an, 1 = bcd, 2 = load_ack
  task automatic checkOutput(input string name, input int n, input int sel, input logic [3:0] exp);
    toCycle(n);
    case (sel)
      0:       compare(name, n, an, exp);
      1:       compare(name, n, bcd, exp);
      default: compare(name, n, {3'b0, load_ack}, exp);
    endcase
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    load      = 1'b0;
    digits_in = '0;
    lz_en     = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    // Free-running scan with a blank display.
    doReset();
    checkOutput("an_c1", 1, 0, 4'b1111);
    checkOutput("an_c2", 2, 0, 4'b1111);
    checkOutput("an_c3", 3, 0, 4'b1110);
    checkOutput("an_c8", 8, 0, 4'b1110);
    checkOutput("an_c9", 9, 0, 4'b1111);
    checkOutput("an_c11", 11, 0, 4'b1101);
    checkOutput("an_c16", 16, 0, 4'b1101);
    checkOutput("bcd_blank", 20, 1, 4'hF);
    checkOutput("an_c27", 27, 0, 4'b0111);
    checkOutput("an_c35", 35, 0, 4'b1110);

    // Single load.
    doReset();
    applyStimulus(5, 16'h1234);
    checkOutput("ack_early", 32, 2, 4'h0);
    checkOutput("ack_1234", 33, 2, 4'h1);
    checkOutput("bcd_d0", 33, 1, 4'h4);
    checkOutput("ack_once", 34, 2, 4'h0);
    checkOutput("bcd_d1", 41, 1, 4'h3);
    checkOutput("bcd_d2", 49, 1, 4'h2);
    checkOutput("bcd_d3", 57, 1, 4'h1);

    // Two loads before the frame end: last one wins, one ack.
    doReset();
    applyStimulus(5, 16'h1111);
    applyStimulus(9, 16'h2222);
    checkOutput("ack_two", 33, 2, 4'h1);
    checkOutput("bcd_two0", 33, 1, 4'h2);
    checkOutput("bcd_two3", 57, 1, 4'h2);
    checkOutput("ack_single", 65, 2, 4'h0);

    // Leading-zero blanking, toggled live.
    doReset();
    lz_en = 1'b1;
    applyStimulus(5, 16'h0070);
    checkOutput("lz1_d0", 33, 1, 4'h0);
    checkOutput("lz1_d1", 41, 1, 4'h7);
    checkOutput("lz1_d2", 49, 1, 4'hF);
    checkOutput("lz1_d3", 57, 1, 4'hF);
    toCycle(58);
    lz_en = 1'b0;
    checkOutput("lz0_d0", 65, 1, 4'h0);
    checkOutput("lz0_d1", 73, 1, 4'h7);
    checkOutput("lz0_d2", 81, 1, 4'h0);
    checkOutput("lz0_d3", 89, 1, 4'h0);
    lz_en = 1'b1;
    applyStimulus(90, 16'h0000);
    checkOutput("ack_zero", 97, 2, 4'h1);
    checkOutput("z_d0", 97, 1, 4'h0);
    checkOutput("z_d1", 105, 1, 4'hF);
    checkOutput("z_d2", 113, 1, 4'hF);
    checkOutput("z_d3", 121, 1, 4'hF);

    // Load coincident with the frame end; codes 11-14 pass through.
    doReset();
    lz_en = 1'b1;
    applyStimulus(5, 16'h5678);
    applyStimulus(32, 16'h0E1B);
    checkOutput("ack_first", 33, 2, 4'h1);
    checkOutput("bcd_first", 33, 1, 4'h8);
    checkOutput("ack_gap", 34, 2, 4'h0);
    checkOutput("ack_pre", 64, 2, 4'h0);
    checkOutput("ack_second", 65, 2, 4'h1);
    checkOutput("bcd_sec0", 65, 1, 4'hB);
    checkOutput("ack_after", 66, 2, 4'h0);
    checkOutput("bcd_sec1", 73, 1, 4'h1);
    checkOutput("bcd_sec2", 81, 1, 4'hE);
    checkOutput("bcd_sec3", 89, 1, 4'hF);

    // Reset mid-frame with a load pending.
    doReset();
    applyStimulus(5, 16'h4321);
    toCycle(19);
    rst_n = 1'b0;
    #1;
    compare("rst_an", 19, {{(4-N){1'b0}}, an}, 4'hF);
    compare("rst_bcd", 19, bcd, 4'hF);
    compare("rst_ack", 19, {3'b0, load_ack}, 4'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    checkOutput("noack_33", 33, 2, 4'h0);
    checkOutput("blank_33", 33, 1, 4'hF);
    checkOutput("blank_41", 41, 1, 4'hF);
    checkOutput("noack_65", 65, 2, 4'h0);
    toCycle(70);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the seven-segment display: sequences the shared 4-bit BCD-to-segment decoder across NUM_DIGITS digit positions. Each digit slot drives the active-low anode and the digit's BCD code, with an anti-ghosting guard band. Leading-zero blanking is optional. New display values are committed tear-free at frame boundaries through a load/ack handshake. Sits between the value-producing logic and the top-level decoder/cathode drive.

## Interface
- NUM_DIGITS, 8: digit positions scanned; legal range 2..8.
- REFRESH_DIV, 100000: clk cycles per digit slot; must be >= 2.
- GUARD, 1000: cycles at the start of each slot with all anodes off; must satisfy 0 <= GUARD < REFRESH_DIV.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  single-cycle request to capture digits_in.
- digits_in  in  4*NUM_DIGITS  packed BCD codes, digit 0 in [3:0] (rightmost).
- lz_en  in  1  1 = blank leading zeros.
- load_ack  out  1  one-cycle pulse when a captured value becomes the displayed frame.
- an  out  NUM_DIGITS  anode enables, active-low, one-hot-low or all ones.
- bcd  out  4  code to decoder: 0-9 digits, 10 minus sign, 15 blank.

## Operation
- State:
  - slot counter cnt, 0..REFRESH_DIV-1, width $clog2(REFRESH_DIV);
  - digit index idx, 0..NUM_DIGITS-1;
  - staging register stg;
  - committed frame register frm;
  - pending flag;
  - registered outputs.
- Scan:
  - cnt increments every cycle.
  - At cnt==REFRESH_DIV-1, cnt wraps to 0 and idx advances; idx wraps NUM_DIGITS-1 -> 0.
- Load:
  - load=1 captures digits_in into stg and sets pending.
  - A load while pending overwrites stg (last request wins); only one ack is issued.
- Commit:
  - Frame end is idx==NUM_DIGITS-1 and cnt==REFRESH_DIV-1.
  - At frame end with pending=1: frm <= stg, pending <= 0, load_ack=1 on the following cycle.
  - If load coincides with frame end: the commit uses the pre-existing stg, the new value lands in stg, and pending stays 1. The new value commits at the next frame end.
- Blanking:
  - With lz_en=1, digit i (i>=1) is forced to 15 when frm digits i..NUM_DIGITS-1 are all 0.
  - Digit 0 is never blanked.
  - Codes 11-14 in frm pass through unchanged; the decoder renders them blank.
  - lz_en is sampled live (not latched per frame).
- Drive:
  - bcd is the (possibly blanked) frm digit at idx.
  - an[idx]=0 only when cnt >= GUARD; all other anode bits are 1.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - cnt=0, idx=0, pending=0;
  - stg and frm all codes 15 (blank display);
  - an all ones, bcd=15, load_ack=0.
- Output latency: an and bcd are registered and reflect (idx, cnt, frm) of the previous cycle, i.e. 1-cycle latency.
- First anode assertion after reset release: an[0] goes low at cycle GUARD+1.
- Digit slot period is REFRESH_DIV cycles; frame period is NUM_DIGITS*REFRESH_DIV cycles.
- Load-to-ack latency:
  - minimum 2 cycles (load one cycle before frame end);
  - maximum NUM_DIGITS*REFRESH_DIV+1 cycles.
- load_ack is high for exactly one cycle per commit.
- The new frame is first visible on bcd in the cycle load_ack is high (slot idx=0).
- Reset asserted mid-frame: all outputs return to reset values immediately; pending loads are discarded and no ack is issued.

## Test plan
Use NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2 unless stated.
- Reset release, no load:
  - an=4'b1111 at cycles 1-2; an=4'b1110 at cycles 3-8; an=4'b1101 at cycles 11-16.
  - bcd=15 throughout; anodes cycle 0->3->0.
- load digits_in=16'h1234 at cycle 5:
  - load_ack pulses at cycle 33.
  - bcd then reads 4,3,2,1 for idx 0..3 on successive slots.
- Two loads, 16'h1111 at cycle 5 and 16'h2222 at cycle 9:
  - a single ack, at cycle 33;
  - displayed digits all 2.
- Load 16'h0070 with lz_en=1:
  - bcd sequence 0,7,15,15.
  - With lz_en=0: 0,7,0,0.
  - Load 16'h0000 with lz_en=1: 0,15,15,15.
- Load coincident with frame end (cycle 32):
  - previous stg commits with an ack at cycle 33;
  - the new value commits with a second ack at cycle 65.
- rst_n pulsed low at cycle 20 with a load pending:
  - an=1111 and bcd=15 immediately;
  - no load_ack afterwards;
  - display blank after reset release.
